// File: rtl/key_debounce_array.sv
// key_debounce_array
// N-channel push-button conditioner for the game controls. Each channel
// synchronises its raw pin, filters it on a shared sample tick so that a
// level change is only accepted after STABLE_SAMPLES consecutive differing
// samples, emits one-cycle press/release strobes, and optionally generates
// auto-repeat strobes while a key is held.
//
// All strobes are registered on the clock edge that accepts the level change,
// so press_pulse and the key_level rise appear together. act_pulse merges
// press and repeat into the single strobe the game FSM consumes.

module key_debounce_array #(
  parameter int N_KEYS         = 4,
  parameter int SAMPLE_DIV     = 200,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 1,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] k,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] repeat_pulse,
  output logic [N_KEYS-1:0] act_pulse
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);

  // A single-sample filter still needs a 1-bit counter so the array is legal.
  localparam int STAB_W = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
  localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_SAMPLES - 1);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_LAST  = RPT_W'(REPEAT_RATE - 1);
  localparam logic [RPT_W-1:0] RPT_SAT    = {RPT_W{1'b1}};

  localparam logic RPT_ON  = (REPEAT_EN != 0);
  localparam logic PIN_INV = (ACTIVE_LOW != 0);

  // Pin level of a released key; the synchroniser resets to it so that reset
  // never looks like a key press.
  localparam logic [N_KEYS-1:0] PIN_IDLE = {N_KEYS{PIN_INV}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_e;

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] sync1_q, sync2_q;
  logic [N_KEYS-1:0] norm;

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;

  logic [STAB_W-1:0] stab_cnt_q [N_KEYS];
  logic [STAB_W-1:0] stab_cnt_d [N_KEYS];
  logic [RPT_W-1:0]  rpt_cnt_q  [N_KEYS];
  logic [RPT_W-1:0]  rpt_cnt_d  [N_KEYS];
  rpt_state_e        state_q    [N_KEYS];
  rpt_state_e        state_d    [N_KEYS];

  logic [N_KEYS-1:0] level_q,   level_d;
  logic [N_KEYS-1:0] press_q,   press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] repeat_q,  repeat_d;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser on the raw asynchronous pins
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its source; a blocking = here would collapse the two
  // synchroniser stages into one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= PIN_IDLE;
      sync2_q <= PIN_IDLE;
    end else begin
      sync1_q <= k;
      sync2_q <= sync1_q;
    end
  end

  // Normalise polarity so that 1 always means "pressed" downstream.
  assign norm = sync2_q ^ PIN_IDLE;

  // ---------------------------------------------------------------------------
  // Shared sample tick: one cycle in every SAMPLE_DIV
  // ---------------------------------------------------------------------------
  assign tick = (tick_cnt_q == TICK_LAST);

  // Next tick count: wrap to 0 after the tick cycle.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Stable-sample filter and edge detection
  // ---------------------------------------------------------------------------
  // Accept a level change after STABLE_SAMPLES consecutive differing samples;
  // any agreeing sample restarts the count. The accepting tick also raises the
  // matching press/release strobe.
  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      stab_cnt_d[i] = stab_cnt_q[i];
      if (tick) begin
        if (norm[i] == level_q[i]) begin
          stab_cnt_d[i] = '0;
        end else if (stab_cnt_q[i] == STAB_LAST) begin
          level_d[i]    = ~level_q[i];
          stab_cnt_d[i] = '0;
          press_d[i]    = ~level_q[i];
          release_d[i]  =  level_q[i];
        end else begin
          // Below STAB_LAST here, so the increment cannot wrap.
          stab_cnt_d[i] = stab_cnt_q[i] + STAB_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-repeat FSM, next-state and repeat strobe
  // ---------------------------------------------------------------------------
  // Advances only on ticks. An accepted release always wins over a repeat due
  // on the same tick. With repeat disabled the channel parks in HOLD and its
  // counter saturates.
  always_comb begin
    repeat_d = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      if (tick) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if (press_d[i]) begin
              state_d[i]   = ST_HOLD;
              rpt_cnt_d[i] = '0;
            end
          end
          ST_HOLD: begin
            if (release_d[i]) begin
              state_d[i]   = ST_IDLE;
              rpt_cnt_d[i] = '0;
            end else if (RPT_ON && (rpt_cnt_q[i] == DELAY_LAST)) begin
              state_d[i]   = ST_REPEAT;
              rpt_cnt_d[i] = '0;
              repeat_d[i]  = 1'b1;
            end else if (rpt_cnt_q[i] != RPT_SAT) begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (release_d[i]) begin
              state_d[i]   = ST_IDLE;
              rpt_cnt_d[i] = '0;
            end else if (rpt_cnt_q[i] == RATE_LAST) begin
              rpt_cnt_d[i] = '0;
              repeat_d[i]  = 1'b1;
            end else if (rpt_cnt_q[i] != RPT_SAT) begin
              rpt_cnt_d[i] = rpt_cnt_q[i] + RPT_W'(1);
            end
          end
          default: begin
            state_d[i]   = ST_IDLE;
            rpt_cnt_d[i] = '0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel state registers
  // ---------------------------------------------------------------------------
  // Filter counters, repeat counters and FSM states for every channel.
  // NOTE: these per-channel arrays are ordinary flops, not a RAM, so they are
  // reset explicitly; reset must leave every channel idle with zeroed counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        stab_cnt_q[i] <= '0;
        rpt_cnt_q[i]  <= '0;
        state_q[i]    <= ST_IDLE;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        stab_cnt_q[i] <= stab_cnt_d[i];
        rpt_cnt_q[i]  <= rpt_cnt_d[i];
        state_q[i]    <= state_d[i];
      end
    end
  end

  // Debounced level and one-cycle strobes; reset clears them without ever
  // producing a release strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign key_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign act_pulse     = press_q | repeat_q;

endmodule

// File: tb/tb_key_debounce_array.sv
// Bench for key_debounce_array: two instances (auto-repeat on / off) share
// clock and reset. A tick-level reference model, written from the behavioural
// rules (sample history window, ticks held since press), predicts every
// output on every cycle; directed steps then check latencies and pulse counts
// against values worked out from the parameters.

module tb_key_debounce_array;

  localparam int N  = 4;
  localparam int SD = 4;   // SAMPLE_DIV
  localparam int SS = 3;   // STABLE_SAMPLES
  localparam int RD = 4;   // REPEAT_DELAY
  localparam int RR = 2;   // REPEAT_RATE

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] k_a, k_b;
  logic [N-1:0] lvl_a, prs_a, rel_a, rpt_a, act_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, rpt_b, act_b;

  always #5 clk = ~clk;

  key_debounce_array #(
    .N_KEYS(N), .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .ACTIVE_LOW(1),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_a (
    .clk(clk), .rst(rst), .k(k_a),
    .key_level(lvl_a), .press_pulse(prs_a), .release_pulse(rel_a),
    .repeat_pulse(rpt_a), .act_pulse(act_a)
  );

  key_debounce_array #(
    .N_KEYS(N), .SAMPLE_DIV(SD), .STABLE_SAMPLES(SS), .ACTIVE_LOW(1),
    .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut_b (
    .clk(clk), .rst(rst), .k(k_b),
    .key_level(lvl_b), .press_pulse(prs_b), .release_pulse(rel_b),
    .repeat_pulse(rpt_b), .act_pulse(act_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // ---------------- reference model state (index 0 = dut_a, 1 = dut_b) -----
  int           m_cycles;          // cycles since reset released
  logic [N-1:0] m_s1 [2];
  logic [N-1:0] m_s2 [2];
  logic [N-1:0] m_lvl [2];
  logic [N-1:0] m_prs [2];
  logic [N-1:0] m_rel [2];
  logic [N-1:0] m_rpt [2];
  logic [15:0]  m_hist [2][N];     // newest sample in bit 0
  int           m_since [2][N];    // samples taken since last level change
  int           m_held  [2][N];    // ticks elapsed since the accepted press

  // ---------------- observed pulse statistics ------------------------------
  int o_prs_n [2][N];
  int o_rel_n [2][N];
  int o_rpt_n [2][N];
  int o_act_n [2][N];
  int o_prs_c [2][N];
  int o_rel_c [2][N];
  int o_rpt_first [2][N];
  int o_rpt_last  [2][N];
  int o_rpt_at_rel [2][N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic clear_obs();
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < N; c++) begin
        o_prs_n[u][c] = 0; o_rel_n[u][c] = 0; o_rpt_n[u][c] = 0; o_act_n[u][c] = 0;
        o_prs_c[u][c] = -1; o_rel_c[u][c] = -1;
        o_rpt_first[u][c] = -1; o_rpt_last[u][c] = -1; o_rpt_at_rel[u][c] = -1;
      end
  endtask

  // Model advance for one clock edge, using the values present at the edge.
  task automatic model_edge(input logic r, input logic [N-1:0] ka, input logic [N-1:0] kb);
    bit   tick;
    bit   accept;
    logic nrm;
    if (r) begin
      m_cycles = 0;
      for (int u = 0; u < 2; u++) begin
        m_s1[u] = '1; m_s2[u] = '1;
        m_lvl[u] = '0; m_prs[u] = '0; m_rel[u] = '0; m_rpt[u] = '0;
        for (int c = 0; c < N; c++) begin
          m_hist[u][c] = '0; m_since[u][c] = 0; m_held[u][c] = 0;
        end
      end
      return;
    end
    tick = ((m_cycles % SD) == SD - 1);
    m_cycles++;
    for (int u = 0; u < 2; u++) begin
      m_prs[u] = '0; m_rel[u] = '0; m_rpt[u] = '0;
      for (int c = 0; c < N; c++) begin
        nrm = ~m_s2[u][c];
        if (tick) begin
          m_hist[u][c] = {m_hist[u][c][14:0], nrm};
          m_since[u][c]++;
          accept = (m_since[u][c] >= SS);
          for (int j = 0; j < SS; j++)
            if (m_hist[u][c][j] == m_lvl[u][c]) accept = 0;
          if (accept) begin
            m_lvl[u][c]   = ~m_lvl[u][c];
            m_since[u][c] = 0;
            if (m_lvl[u][c]) begin
              m_prs[u][c]  = 1'b1;
              m_held[u][c] = 0;
            end else begin
              m_rel[u][c] = 1'b1;
            end
          end else if (m_lvl[u][c]) begin
            m_held[u][c]++;
            if (u == 0 && m_held[u][c] >= RD && ((m_held[u][c] - RD) % RR) == 0)
              m_rpt[u][c] = 1'b1;
          end
        end
      end
      m_s2[u] = m_s1[u];
      m_s1[u] = (u == 0) ? ka : kb;
    end
  endtask

  // One clock: advance model, sample DUTs 1 time unit after the edge, compare.
  task automatic step();
    logic [N-1:0] op [2];
    logic [N-1:0] orl [2];
    logic [N-1:0] orp [2];
    logic [N-1:0] oa  [2];
    @(posedge clk);
    model_edge(rst, k_a, k_b);
    #1;
    cyc++;
    check("lvl_a", 32'(lvl_a), 32'(m_lvl[0]));
    check("prs_a", 32'(prs_a), 32'(m_prs[0]));
    check("rel_a", 32'(rel_a), 32'(m_rel[0]));
    check("rpt_a", 32'(rpt_a), 32'(m_rpt[0]));
    check("act_a", 32'(act_a), 32'(m_prs[0] | m_rpt[0]));
    check("lvl_b", 32'(lvl_b), 32'(m_lvl[1]));
    check("prs_b", 32'(prs_b), 32'(m_prs[1]));
    check("rel_b", 32'(rel_b), 32'(m_rel[1]));
    check("rpt_b", 32'(rpt_b), 32'(m_rpt[1]));
    check("act_b", 32'(act_b), 32'(m_prs[1] | m_rpt[1]));
    op[0] = prs_a; orl[0] = rel_a; orp[0] = rpt_a; oa[0] = act_a;
    op[1] = prs_b; orl[1] = rel_b; orp[1] = rpt_b; oa[1] = act_b;
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < N; c++) begin
        if (op[u][c])  begin o_prs_n[u][c]++; o_prs_c[u][c] = cyc; end
        if (oa[u][c])  o_act_n[u][c]++;
        if (orp[u][c]) begin
          o_rpt_n[u][c]++;
          if (o_rpt_first[u][c] < 0) o_rpt_first[u][c] = cyc;
          o_rpt_last[u][c] = cyc;
        end
        if (orl[u][c]) begin
          o_rel_n[u][c]++; o_rel_c[u][c] = cyc; o_rpt_at_rel[u][c] = int'(orp[u][c]);
        end
      end
  endtask

  task automatic steps(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  int t0;
  int lat;
  int dur [2][N];

  initial begin
    rst = 1'b1; k_a = '1; k_b = '1;
    clear_obs();
    steps(3);
    check("reset_outputs_a", 32'({lvl_a, prs_a, rel_a, rpt_a, act_a}), 32'd0);
    check("reset_outputs_b", 32'({lvl_b, prs_b, rel_b, rpt_b, act_b}), 32'd0);
    rst = 1'b0;
    steps(5);

    // 1. Clean press on channel 0.
    clear_obs();
    k_a[0] = 1'b0; t0 = cyc;
    steps(40);
    lat = o_prs_c[0][0] - t0;
    check("t1_press_count", 32'(o_prs_n[0][0]), 32'd1);
    check("t1_latency_in_11_14", 32'(lat >= 11 && lat <= 14), 32'd1);
    check("t1_level_held", 32'(lvl_a[0]), 32'd1);
    check("t1_other_presses", 32'(o_prs_n[0][1] + o_prs_n[0][2] + o_prs_n[0][3]), 32'd0);
    k_a[0] = 1'b1;
    steps(30);

    // 2. Bounce every 3 cycles on channel 1 must be rejected.
    clear_obs();
    for (int t = 0; t < 16; t++) begin
      k_a[1] = ~k_a[1];
      steps(3);
    end
    steps(20);
    check("t2_no_press", 32'(o_prs_n[0][1]), 32'd0);
    check("t2_no_release", 32'(o_rel_n[0][1]), 32'd0);
    check("t2_level_low", 32'(lvl_a[1]), 32'd0);

    // 3. Hold channel 2 for 60 cycles: repeats at T+4, T+6, ... T+14, release at T+15.
    clear_obs();
    k_a[2] = 1'b0;
    steps(60);
    k_a[2] = 1'b1;
    steps(30);
    check("t3_press_count", 32'(o_prs_n[0][2]), 32'd1);
    check("t3_repeat_count", 32'(o_rpt_n[0][2]), 32'd6);
    check("t3_first_repeat_gap", 32'(o_rpt_first[0][2] - o_prs_c[0][2]), 32'(RD * SD));
    check("t3_last_repeat_gap", 32'(o_rpt_last[0][2] - o_prs_c[0][2]), 32'(RD * SD + 5 * RR * SD));
    check("t3_release_count", 32'(o_rel_n[0][2]), 32'd1);
    check("t3_release_gap", 32'(o_rel_c[0][2] - o_prs_c[0][2]), 32'd60);
    check("t3_act_count", 32'(o_act_n[0][2]), 32'd7);

    // 4. Release accepted on the tick where the second repeat would fall (T+6).
    clear_obs();
    k_a[2] = 1'b0;
    steps(24);
    k_a[2] = 1'b1;
    steps(30);
    check("t4_release_gap", 32'(o_rel_c[0][2] - o_prs_c[0][2]), 32'(6 * SD));
    check("t4_repeat_at_release", 32'(o_rpt_at_rel[0][2]), 32'd0);
    check("t4_repeat_count", 32'(o_rpt_n[0][2]), 32'd1);

    // 5. One-cycle reset while channel 3 is auto-repeating.
    clear_obs();
    k_a[3] = 1'b0;
    steps(40);
    check("t5_was_repeating", 32'(o_rpt_n[0][3] > 0), 32'd1);
    rst = 1'b1;
    step();
    check("t5_reset_outputs_a", 32'({lvl_a, prs_a, rel_a, rpt_a, act_a}), 32'd0);
    rst = 1'b0; t0 = cyc;
    clear_obs();
    steps(20);
    check("t5_repress_latency", 32'(o_prs_c[0][3] - t0), 32'(SS * SD));
    check("t5_no_release", 32'(o_rel_n[0][3]), 32'd0);
    k_a[3] = 1'b1;
    steps(30);

    // 6. Simultaneous press on the repeat-disabled instance.
    clear_obs();
    k_b[1:0] = 2'b00;
    steps(60);
    check("t6_press_count0", 32'(o_prs_n[1][0]), 32'd1);
    check("t6_press_count1", 32'(o_prs_n[1][1]), 32'd1);
    check("t6_same_cycle", 32'(o_prs_c[1][0] == o_prs_c[1][1]), 32'd1);
    check("t6_no_repeat", 32'(o_rpt_n[1][0] + o_rpt_n[1][1]), 32'd0);
    check("t6_levels", 32'(lvl_b[1:0]), 32'd3);
    k_b[1:0] = 2'b11;
    steps(30);

    // 7. Random pin activity on both instances with occasional resets.
    for (int u = 0; u < 2; u++)
      for (int c = 0; c < N; c++) dur[u][c] = $urandom_range(1, 40);
    for (int t = 0; t < 1500; t++) begin
      for (int c = 0; c < N; c++) begin
        if (--dur[0][c] == 0) begin k_a[c] = ~k_a[c]; dur[0][c] = $urandom_range(1, 40); end
        if (--dur[1][c] == 0) begin k_b[c] = ~k_b[c]; dur[1][c] = $urandom_range(1, 40); end
      end
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    steps(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
